// File: rtl/iramsp_arb.sv
`default_nettype none
// ============================================================================
// Module   : iramsp_arb
// Purpose  : Four-requester round-robin arbiter in front of a single-port RAM
//            with registered command and tagged 2-cycle read return.
// Options  : IRAMSP_ARB_WRPRI_EN - writes win over reads; round-robin per class
// Revision : 1.0 - initial release
// ============================================================================
module iramsp_arb #(
    parameter int ADDRBIT = 11,
    parameter int DEPTH   = 1536,
    parameter int WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 test,
    input  logic [3:0]           req_vld,
    input  logic [3:0]           req_wr,
    input  logic [4*ADDRBIT-1:0] req_a,
    input  logic [4*WIDTH-1:0]   req_di,
    output logic [3:0]           req_ack,
    output logic [3:0]           rd_vld,
    output logic [WIDTH-1:0]     rd_do,
    output logic [3:0]           err_addr,
    output logic [ADDRBIT-1:0]   ram_a,
    output logic                 ram_we,
    output logic                 ram_re,
    output logic [WIDTH-1:0]     ram_di,
    input  logic [WIDTH-1:0]     ram_do
);

    localparam logic [31:0] c_DEPTH = 32'(DEPTH);

    logic [1:0]         r_last;
    logic [ADDRBIT-1:0] r_ram_a;
    logic               r_ram_we;
    logic               r_ram_re;
    logic [WIDTH-1:0]   r_ram_di;
    logic [3:0]         r_err_addr;
    logic [1:0]         r_rd_tag;
    logic               r_rd_pend;
    logic [1:0]         r_rd_tag2;
    logic               r_rd_pend2;

    logic [3:0]         w_cand;
    logic               w_any;
    logic [1:0]         w_sel;
    logic [1:0]         w_idx;
    logic               w_sel_wr;
    logic [ADDRBIT-1:0] w_sel_a;
    logic [WIDTH-1:0]   w_sel_di;
    logic               w_legal;

`ifdef IRAMSP_ARB_WRPRI_EN
    // Reads only compete when no write is pending anywhere.
    always_comb begin
        w_cand = req_vld;
        if (|(req_vld & req_wr)) begin
            w_cand = req_vld & req_wr;
        end
    end
`else
    always_comb begin
        w_cand = req_vld;
    end
`endif

    // Search starts one past the last winner; k=4 wraps back onto it.
    always_comb begin
        w_any = 1'b0;
        w_sel = 2'd0;
        w_idx = 2'd0;
        if (!rst && !test) begin
            for (int k = 1; k <= 4; k++) begin
                w_idx = r_last + 2'(k);
                if (!w_any && w_cand[w_idx]) begin
                    w_any = 1'b1;
                    w_sel = w_idx;
                end
            end
        end
    end

    assign w_sel_wr = req_wr[w_sel];
    assign w_sel_a  = req_a[int'(w_sel)*ADDRBIT +: ADDRBIT];
    assign w_sel_di = req_di[int'(w_sel)*WIDTH +: WIDTH];
    assign w_legal  = 32'(w_sel_a) < c_DEPTH;

    assign req_ack = w_any ? (4'b0001 << w_sel) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= 2'd3;
            r_ram_a    <= '0;
            r_ram_we   <= 1'b0;
            r_ram_re   <= 1'b0;
            r_ram_di   <= '0;
            r_err_addr <= 4'b0000;
            r_rd_tag   <= 2'd0;
            r_rd_pend  <= 1'b0;
            r_rd_tag2  <= 2'd0;
            r_rd_pend2 <= 1'b0;
        end else begin
            r_ram_we   <= 1'b0;
            r_ram_re   <= 1'b0;
            r_err_addr <= 4'b0000;
            r_rd_pend  <= 1'b0;
            r_rd_tag2  <= r_rd_tag;
            r_rd_pend2 <= r_rd_pend;
            if (w_any) begin
                r_last <= w_sel;
                if (w_legal) begin
                    r_ram_a   <= w_sel_a;
                    r_ram_we  <= w_sel_wr;
                    r_ram_re  <= !w_sel_wr;
                    r_rd_pend <= !w_sel_wr;
                    r_rd_tag  <= w_sel;
                    if (w_sel_wr) begin
                        r_ram_di <= w_sel_di;
                    end
                end else begin
                    // Out-of-range access is consumed but never reaches the RAM.
                    r_err_addr <= 4'b0001 << w_sel;
                end
            end
        end
    end

    assign ram_a    = r_ram_a;
    assign ram_we   = r_ram_we;
    assign ram_re   = r_ram_re;
    assign ram_di   = r_ram_di;
    assign err_addr = r_err_addr;
    assign rd_vld   = r_rd_pend2 ? (4'b0001 << r_rd_tag2) : 4'b0000;
    assign rd_do    = ram_do;

endmodule
`default_nettype wire

// File: tb/tb_iramsp_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_iramsp_arb
// Purpose  : Directed self-checking bench for iramsp_arb with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iramsp_arb;

    localparam int ADDRBIT = 11;
    localparam int DEPTH   = 1536;
    localparam int WIDTH   = 32;

    logic                 clk;
    logic                 rst;
    logic                 test;
    logic [3:0]           req_vld;
    logic [3:0]           req_wr;
    logic [4*ADDRBIT-1:0] req_a;
    logic [4*WIDTH-1:0]   req_di;
    logic [3:0]           req_ack;
    logic [3:0]           rd_vld;
    logic [WIDTH-1:0]     rd_do;
    logic [3:0]           err_addr;
    logic [ADDRBIT-1:0]   ram_a;
    logic                 ram_we;
    logic                 ram_re;
    logic [WIDTH-1:0]     ram_di;
    logic [WIDTH-1:0]     ram_do;

    logic [WIDTH-1:0]     mem [0:(1<<ADDRBIT)-1];

    int errors = 0;
    int checks = 0;

    iramsp_arb #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .test(test),
        .req_vld(req_vld), .req_wr(req_wr), .req_a(req_a), .req_di(req_di),
        .req_ack(req_ack), .rd_vld(rd_vld), .rd_do(rd_do), .err_addr(err_addr),
        .ram_a(ram_a), .ram_we(ram_we), .ram_re(ram_re), .ram_di(ram_di),
        .ram_do(ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_di;
        if (ram_re) ram_do <= mem[ram_a];
    end

    function automatic logic [31:0] pat(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Advance to the middle of the next cycle; inputs change here, outputs settle by #1.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic wr, input int a, input logic [31:0] di);
        req_wr[i] = wr;
        req_a[i*ADDRBIT +: ADDRBIT] = ADDRBIT'(a);
        req_di[i*WIDTH +: WIDTH] = di;
    endtask

    task automatic pulse_reset();
        cyc(); rst = 1'b1; req_vld = 4'b0000;
        cyc(); rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc(); #1;
        checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", req_ack); end
        checks++; if ({ram_we, ram_re} !== 2'b00) begin errors++; $display("FAIL reset_we_re got=%b exp=00", {ram_we, ram_re}); end
        checks++; if (ram_a !== '0 || ram_di !== '0) begin errors++; $display("FAIL reset_a_di got=%h/%h exp=0/0", ram_a, ram_di); end
        checks++; if (rd_vld !== 4'b0000 || err_addr !== 4'b0000) begin errors++; $display("FAIL reset_vld_err got=%b/%b exp=0000/0000", rd_vld, err_addr); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc(); #1;
            checks++;
            if ({req_ack, rd_vld, err_addr, ram_we, ram_re} !== 14'd0) begin
                errors++; $display("FAIL idle_c%0d got ack=%b vld=%b err=%b we=%b re=%b exp=all 0", c, req_ack, rd_vld, err_addr, ram_we, ram_re);
            end
        end
    endtask

    task automatic test_write_read();
        cyc(); set_req(0, 1'b1, 5, 32'hDEADBEEF); req_vld = 4'b0001; #1;
        checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL wr_ack got=%b exp=0001", req_ack); end
        cyc(); set_req(0, 1'b0, 5, 32'h0); #1;
        checks++; if ({ram_we, ram_re} !== 2'b10 || ram_a !== 11'h005 || ram_di !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_cmd got we=%b re=%b a=%h di=%h exp we=1 re=0 a=005 di=deadbeef", ram_we, ram_re, ram_a, ram_di); end
        checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL rd_ack got=%b exp=0001", req_ack); end
        cyc(); req_vld = 4'b0000; #1;
        checks++; if ({ram_we, ram_re} !== 2'b01) begin errors++; $display("FAIL rd_cmd got=%b exp=01", {ram_we, ram_re}); end
        checks++; if (rd_vld !== 4'b0000) begin errors++; $display("FAIL rd_early got=%b exp=0000", rd_vld); end
        cyc(); #1;
        checks++; if (rd_vld !== 4'b0001 || rd_do !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_ret got vld=%b do=%h exp vld=0001 do=deadbeef", rd_vld, rd_do); end
        cyc(); #1;
        checks++; if (rd_vld !== 4'b0000) begin errors++; $display("FAIL rd_once got=%b exp=0000", rd_vld); end
    endtask

    task automatic test_rr_all();
        logic [3:0] ea;
        logic [3:0] ev;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 'h100 + i, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            req_vld = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            ea = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            ev = (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000;
            checks++; if (req_ack !== ea) begin errors++; $display("FAIL rr_ack_k%0d got=%b exp=%b", k, req_ack, ea); end
            checks++; if (rd_vld !== ev) begin errors++; $display("FAIL rr_vld_k%0d got=%b exp=%b", k, rd_vld, ev); end
            if (k >= 2) begin
                checks++; if (rd_do !== pat('h100 + (k - 2) % 4)) begin
                    errors++; $display("FAIL rr_do_k%0d got=%h exp=%h", k, rd_do, pat('h100 + (k - 2) % 4)); end
            end
            checks++; if (ram_we && ram_re) begin errors++; $display("FAIL rr_collide_k%0d got we=1 re=1 exp not both", k); end
        end
        cyc(); #1;
        checks++; if (rd_vld !== 4'b0000) begin errors++; $display("FAIL rr_drain got=%b exp=0000", rd_vld); end
    endtask

    task automatic test_err_addr();
        cyc(); set_req(2, 1'b0, DEPTH, 32'h0); req_vld = 4'b0100; #1;
        checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL err_ack got=%b exp=0100", req_ack); end
        cyc(); req_vld = 4'b0000; #1;
        checks++; if (err_addr !== 4'b0100) begin errors++; $display("FAIL err_pulse got=%b exp=0100", err_addr); end
        checks++; if ({ram_we, ram_re} !== 2'b00) begin errors++; $display("FAIL err_noacc got=%b exp=00", {ram_we, ram_re}); end
        cyc(); #1;
        checks++; if (err_addr !== 4'b0000 || rd_vld !== 4'b0000) begin
            errors++; $display("FAIL err_after got err=%b vld=%b exp 0000/0000", err_addr, rd_vld); end
        cyc(); #1;
        checks++; if (rd_vld !== 4'b0000) begin errors++; $display("FAIL err_novld got=%b exp=0000", rd_vld); end
    endtask

    task automatic test_test_mode();
        cyc(); set_req(1, 1'b0, 'h101, 32'h0); set_req(3, 1'b0, 'h103, 32'h0); req_vld = 4'b0010; #1;
        checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL tm_ack1 got=%b exp=0010", req_ack); end
        cyc(); test = 1'b1; req_vld = 4'b1000; #1;
        checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL tm_noack_a got=%b exp=0000", req_ack); end
        cyc(); #1;
        checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL tm_noack_b got=%b exp=0000", req_ack); end
        checks++; if (rd_vld !== 4'b0010 || rd_do !== pat('h101)) begin
            errors++; $display("FAIL tm_rdret got vld=%b do=%h exp vld=0010 do=%h", rd_vld, rd_do, pat('h101)); end
        checks++; if ({ram_we, ram_re} !== 2'b00) begin errors++; $display("FAIL tm_idle got=%b exp=00", {ram_we, ram_re}); end
        cyc(); test = 1'b0; #1;
        checks++; if (req_ack !== 4'b1000) begin errors++; $display("FAIL tm_resume got=%b exp=1000", req_ack); end
        cyc(); req_vld = 4'b0000; #1;
        checks++; if (ram_re !== 1'b1 || ram_a !== 11'h103) begin errors++; $display("FAIL tm_cmd3 got re=%b a=%h exp re=1 a=103", ram_re, ram_a); end
        cyc(); #1;
        checks++; if (rd_vld !== 4'b1000 || rd_do !== pat('h103)) begin
            errors++; $display("FAIL tm_rdret3 got vld=%b do=%h exp vld=1000 do=%h", rd_vld, rd_do, pat('h103)); end
    endtask

    task automatic test_reset_midflight();
        cyc(); set_req(0, 1'b0, 'h100, 32'h0); req_vld = 4'b0001; #1;
        checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL mr_ack got=%b exp=0001", req_ack); end
        cyc(); rst = 1'b1; req_vld = 4'b0000; #1;
        checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL mr_re got=%b exp=0", ram_re); end
        cyc(); rst = 1'b0; #1;
        checks++; if (rd_vld !== 4'b0000) begin errors++; $display("FAIL mr_vld_a got=%b exp=0000", rd_vld); end
        cyc(); #1;
        checks++; if (rd_vld !== 4'b0000) begin errors++; $display("FAIL mr_vld_b got=%b exp=0000", rd_vld); end
    endtask

    task automatic test_wrpri();
        logic [3:0] first;
        logic [3:0] second;
`ifdef IRAMSP_ARB_WRPRI_EN
        first = 4'b0100; second = 4'b0010;
`else
        first = 4'b0010; second = 4'b0100;
`endif
        cyc(); set_req(1, 1'b0, 'h102, 32'h0); set_req(2, 1'b1, 'h110, 32'h12345678); req_vld = 4'b0110; #1;
        checks++; if (req_ack !== first) begin errors++; $display("FAIL pri_first got=%b exp=%b", req_ack, first); end
        cyc(); req_vld = second; #1;
        checks++; if (req_ack !== second) begin errors++; $display("FAIL pri_second got=%b exp=%b", req_ack, second); end
        checks++; if ({ram_we, ram_re} !== (first[2] ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL pri_cmd1 got=%b exp=%b", {ram_we, ram_re}, first[2] ? 2'b10 : 2'b01); end
        cyc(); req_vld = 4'b0000; #1;
        checks++; if ({ram_we, ram_re} !== (first[2] ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL pri_cmd2 got=%b exp=%b", {ram_we, ram_re}, first[2] ? 2'b01 : 2'b10); end
        cyc(); cyc(); #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDRBIT); i++) mem[i] = pat(i);
        ram_do  = '0;
        rst     = 1'b1;
        test    = 1'b0;
        req_vld = 4'b0000;
        req_wr  = 4'b0000;
        req_a   = '0;
        req_di  = '0;
        test_reset();
        test_write_read();
        test_rr_all();
        test_err_addr();
        test_test_mode();
        test_reset_midflight();
        test_wrpri();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
